// File: rtl/tt_probe.sv
// tt_probe: steps a 3-input gate through rows 000..111 and captures its truth table.
// Define TT_PROBE_GLITCH_CHECK_EN to add a per-row CHECK resample that flags unstable rows.
module tt_probe #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       probe_out,
    output logic       probe_in1,
    output logic       probe_in2,
    output logic       probe_in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt,
    output logic       tt_valid,
    output logic [7:0] unstable
);
`ifdef TT_PROBE_GLITCH_CHECK_EN
    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, CHECK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
`endif
    // SAMPLE is the last of the SETTLE_CYCLES hold cycles, so SETTLE itself lasts one fewer
    localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 2);
    localparam state_t FIRST = (SETTLE_CYCLES == 1) ? SAMPLE : SETTLE;

    state_t     state, nxt;
    logic [2:0] r;
    logic [7:0] cnt;
    logic [6:0] sr;
    logic       go, stop, row_end, bit_in;

    assign go   = state == IDLE && start && !abort;
    assign stop = busy && abort;
    assign {probe_in1, probe_in2, probe_in3} = r;

    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:   nxt = go ? FIRST : IDLE;
            SETTLE: nxt = abort ? IDLE : (cnt == LAST ? SAMPLE : SETTLE);
`ifdef TT_PROBE_GLITCH_CHECK_EN
            SAMPLE: nxt = abort ? IDLE : CHECK;
            CHECK:  nxt = abort ? IDLE : (r == 3'd7 ? DONE : FIRST);
`else
            SAMPLE: nxt = abort ? IDLE : (r == 3'd7 ? DONE : FIRST);
`endif
            DONE:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
`ifdef TT_PROBE_GLITCH_CHECK_EN
        busy    = state == SETTLE || state == SAMPLE || state == CHECK;
        row_end = state == CHECK;
`else
        busy    = state == SETTLE || state == SAMPLE;
        row_end = state == SAMPLE;
`endif
        done = state == DONE;
    end

`ifdef TT_PROBE_GLITCH_CHECK_EN
    logic smp;
    assign bit_in = smp;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smp      <= 1'b0;
            unstable <= 8'h00;
        end else if (go) begin
            unstable <= 8'h00;
        end else if (!stop) begin
            if (state == SAMPLE)
                smp <= probe_out;
            if (state == CHECK && probe_out != smp)
                unstable[3'd7 - r] <= 1'b1;
        end
    end
`else
    assign bit_in   = probe_out;
    assign unstable = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r        <= 3'd0;
            cnt      <= 8'd0;
            sr       <= 7'd0;
            tt       <= 8'h00;
            tt_valid <= 1'b0;
        end else if (go || stop) begin
            r        <= 3'd0;
            cnt      <= 8'd0;
            tt_valid <= 1'b0;
        end else begin
            cnt <= (state == SETTLE && cnt != LAST) ? cnt + 8'd1 : 8'd0;
            if (row_end) begin
                r  <= r == 3'd7 ? 3'd0 : r + 3'd1;
                sr <= {sr[5:0], bit_in};
            end
            if (row_end && r == 3'd7) begin
                tt       <= {sr, bit_in};
                tt_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tt_probe.sv
// tb_tt_probe: random and directed runs of tt_probe against a truth-table gate model.
module tb_tt_probe;
    parameter int S = 4;
`ifdef TT_PROBE_GLITCH_CHECK_EN
    localparam int P = S + 1;
`else
    localparam int P = S;
`endif

    logic       clk = 0;
    logic       rst_n, start, abort, probe_out;
    logic       probe_in1, probe_in2, probe_in3, busy, done, tt_valid;
    logic [7:0] tt, unstable;
    logic [7:0] gate_f, model_tt;
    logic       glitch_on;
    int         k;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    // the gate is its own truth table; optionally inverted only in row 3's CHECK cycle
    assign probe_out = gate_f[3'd7 - {probe_in1, probe_in2, probe_in3}] ^ (glitch_on && k == 4 * P - 1);

    tt_probe #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .probe_out(probe_out),
        .probe_in1(probe_in1), .probe_in2(probe_in2), .probe_in3(probe_in3),
        .busy(busy), .done(done), .tt(tt), .tt_valid(tt_valid), .unstable(unstable)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [7:0] f, input bit glitch, input int ab_k, input int rs_k, input bit restarts);
        int pulses;
        gate_f    = f;
        glitch_on = glitch;
        start     = 1;
        @(posedge clk); #1;
        start = 0;
        check("busy_on", busy, 1);
        check("valid_clr", tt_valid, 0);
        for (int c = 0; c <= 8 * P + 1; c++) begin
            k = c;
            check("done", done, c == 8 * P);
            check("busy", busy, c < 8 * P);
            check("probes", {probe_in1, probe_in2, probe_in3}, c < 8 * P ? c / P : 0);
            if (c < 8 * P)
                check("tt_run", tt, model_tt);
            if (c == 8 * P) begin
                model_tt = f;
                check("tt", tt, f);
                check("tt_valid", tt_valid, 1);
                check("unstable", unstable, glitch ? 8'h10 : 8'h00);
            end
            if (c == 8 * P + 1) begin
                check("tt_hold", tt, model_tt);
                check("valid_hold", tt_valid, 1);
            end
            abort = c == ab_k;
            rst_n = c != rs_k;
            start = restarts && (c == 5 || c == 20);
            if (c == ab_k || c == rs_k) begin
                @(posedge clk); #1;
                if (c == rs_k)
                    model_tt = 8'h00;
                abort = 0;
                rst_n = 1;
                start = 0;
                check("cut_busy", busy, 0);
                check("cut_done", done, 0);
                check("cut_valid", tt_valid, 0);
                check("cut_tt", tt, model_tt);
                check("cut_probes", {probe_in1, probe_in2, probe_in3}, 0);
                check("cut_unstable", unstable, 0);
                pulses = 0;
                repeat (8 * P + 2) begin
                    @(posedge clk); #1;
                    pulses += int'(done);
                end
                check("no_done", pulses, 0);
                return;
            end
            @(posedge clk); #1;
        end
        start = 0;
    endtask

    initial begin
        rst_n = 0; start = 0; abort = 0; gate_f = 0; glitch_on = 0; k = -100; model_tt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tt", tt, 0);
        check("rst_valid", tt_valid, 0);
        check("rst_unstable", unstable, 0);
        check("rst_probes", {probe_in1, probe_in2, probe_in3}, 0);
        start = 1; abort = 1;
        @(posedge clk); #1;
        start = 0; abort = 0;
        check("abort_wins", busy, 0);
        run(8'h39, 0, -1, -1, 0);
        run(8'h80, 0, -1, -1, 0);
        run(8'hFF, 0, -1, -1, 0);
        run(8'h39, 0, -1, -1, 0);
        run(8'($urandom), 0, 10, -1, 0);
        run(8'h39, 0, -1, -1, 1);
        run(8'($urandom), 0, -1, 15, 0);
`ifdef TT_PROBE_GLITCH_CHECK_EN
        run(8'h39, 1, -1, -1, 0);
`endif
        for (int i = 0; i < 12; i++)
            run(8'($urandom), 0, $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 8 * P - 1)) : -1,
                -1, 1'($urandom_range(0, 1)));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/tt_probe.md
TT_PROBE -- requirements
Module: tt_probe

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, giving the cycles each input row is held before sampling; legal range 1..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a single-cycle request to characterise the attached 3-input gate.
REQ-005 SHALL have port abort, input, 1, which cancels a run in progress.
REQ-006 SHALL have ports probe_in1, probe_in2, probe_in3, output, 1 each, which drive the gate inputs in1, in2, in3.
REQ-007 SHALL have port probe_out, input, 1, the gate output; it is synchronous to clk.
REQ-008 SHALL have port busy, output, 1, high while a run is in progress.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse when a run completes.
REQ-010 SHALL have port tt, output, 8, the captured truth table.
REQ-011 SHALL have port tt_valid, output, 1, high while tt holds the result of a completed run.
REQ-012 SHALL have port unstable, output, 8, with one glitch flag per row (see Configuration).

Function
REQ-013 SHALL use the row index r = {in1, in2, in3} with in1 as the MSB, and step r from 0 to 7.
REQ-014 SHALL store the value sampled for row r in tt[7-r], so row 000 lands in the MSB.
REQ-015 SHALL implement states IDLE, SETTLE, SAMPLE, CHECK and DONE; CHECK exists only when the macro is defined.
REQ-016 SHALL move from IDLE to SETTLE on a clock edge where start=1. On that edge it sets r=0, clears the settle counter, sets busy=1, and deasserts tt_valid.
REQ-017 SHALL hold SETTLE for SETTLE_CYCLES cycles with the probe inputs driven to r, then sample probe_out into the row shift register on the edge that ends the last of those cycles.
REQ-018 SHALL then advance r and re-enter SETTLE if r<7, or go to DONE if r=7. The row count SHALL NOT wrap past 7.
REQ-019 SHALL, in DONE, hold for one cycle. In that cycle it loads tt, sets tt_valid=1, pulses done=1, drops busy to 0, returns the probe inputs to 000, and then enters IDLE.
REQ-020 SHALL assert done exactly 8*SETTLE_CYCLES cycles after the start edge, or 8*(SETTLE_CYCLES+1) cycles with the macro defined.
REQ-021 SHALL ignore start while busy=1.
REQ-022 SHALL, when abort=1 while busy=1, enter IDLE on that edge. It then drives busy=0, probe inputs 000, done=0 and tt_valid=0, and leaves tt unchanged.
REQ-023 SHALL give abort priority over start when both are high in IDLE; neither action is taken.
REQ-024 SHALL keep tt and tt_valid stable between runs until the next accepted start.
REQ-025 SHALL drive the probe outputs from registers, so the gate sees no combinational glitches.

Reset
REQ-026 SHALL, on a clock edge with rst_n=0, enter IDLE and set busy=0, done=0, tt=8'h00, tt_valid=0, unstable=8'h00, probe inputs 000, and all counters to 0.
REQ-027 SHALL discard a run in progress when reset is asserted mid-run; no done pulse follows.

Configuration
REQ-028 SHALL use macro TT_PROBE_GLITCH_CHECK_EN.
REQ-029 SHALL, with the macro defined, follow SAMPLE with one CHECK cycle for each row. CHECK resamples probe_out and sets unstable[7-r] if it differs from the first sample, and tt keeps the first sample. unstable is cleared on an accepted start and is valid alongside tt_valid.
REQ-030 SHALL, without the macro, have no CHECK state and drive unstable constant 8'h00.

Verification
REQ-031 SHALL pass this directed scenario: SETTLE_CYCLES=4, gate out = in2 XOR (in1 AND NOT in3), pulse start -> done 32 cycles later, tt=8'h39, tt_valid=1, unstable=8'h00.
REQ-032 SHALL pass this directed scenario: gate model out = NOT(in1 OR in2 OR in3) -> tt=8'h80; gate model out=1 constantly -> tt=8'hFF.
REQ-033 SHALL pass this directed scenario: abort at cycle 10 of a run -> busy=0 next cycle, tt_valid=0, tt keeps its prior 8'h39, no done pulse.
REQ-034 SHALL pass this directed scenario: start pulsed again at cycles 5 and 20 of a run -> ignored, single done at cycle 32.
REQ-035 SHALL pass this directed scenario: rst_n=0 for one cycle at cycle 15 -> all outputs at reset values next cycle, no done pulse.
REQ-036 SHALL pass this directed scenario: macro defined, gate model toggles its output only during the CHECK cycle of row 3 -> unstable=8'h10, done at cycle 40.
